// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: reads back a time-multiplexed, active-low seven-segment bus.
// Each digit is sampled once per select dwell after the synchronised select has
// been stable for SETTLE cycles, decoded to a hex nibble, and collected into a
// frame. A full frame is published as value/neg with a one-cycle frame_valid.
// Optional feature: define SSEG_CAP_CONFIRM_EN to publish a frame only when it
// equals the previously completed frame (value and sign).

module sseg_scan_capture #(
    parameter int unsigned N_DIGITS = 2,
    parameter int unsigned SETTLE   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            segs_n,
    input  logic [N_DIGITS-1:0]   dig_en,
    output logic [4*N_DIGITS-1:0] value,
    output logic                  neg,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam int unsigned W  = 4 * N_DIGITS;
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [7:0]          SettleMax = 8'(SETTLE);
    localparam logic [IW-1:0]       TopIdx    = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] SelOne    = N_DIGITS'(1);

    typedef enum logic [1:0] {StIdle, StCollect, StPublish} state_t;

    logic [6:0]          seg_meta, seg;
    logic [N_DIGITS-1:0] sel_meta, sel;
    logic [7:0]          cnt;

    state_t              state;
    logic [N_DIGITS-1:0] mask;
    logic [W-1:0]        pending;
    logic                psign;

    logic                strobe, sel_multi, next_multi, multi_entry, capture;
    logic [IW-1:0]       idx;
    logic [3:0]          nib;
    logic                glyph_ok, is_minus, cap_ok;
    logic [N_DIGITS-1:0] mask_base, mask_new;
    logic                sign_base;

`ifdef SSEG_CAP_CONFIRM_EN
    logic [W-1:0]        cmp_val;
    logic                cmp_neg;
    logic                cmp_loaded;
`endif

    // Two-flop synchronisers for the segment bus and the digit selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta <= '0;
            seg      <= '0;
            sel_meta <= '0;
            sel      <= '0;
        end else begin
            seg_meta <= segs_n;
            seg      <= seg_meta;
            sel_meta <= dig_en;
            sel      <= sel_meta;
        end
    end

    // Stability counter: reads 0 in the first cycle sel holds a new value, then
    // counts up and saturates at SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sel_meta != sel) begin
            cnt <= '0;
        end else if (cnt != SettleMax) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Strobe, select classification and the index of the active digit
    always_comb begin
        strobe      = (sel_meta == sel) && (cnt == SettleMax - 8'd1);
        sel_multi   = |(sel & (sel - SelOne));
        next_multi  = |(sel_meta & (sel_meta - SelOne));
        multi_entry = next_multi && !sel_multi;
        capture     = strobe && (sel != '0) && !sel_multi;
        idx         = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (sel[i]) idx = IW'(i);
        end
    end

    // Active-low glyph decode, bit6=g .. bit0=a
    always_comb begin
        nib      = 4'h0;
        glyph_ok = 1'b1;
        is_minus = 1'b0;
        case (seg)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            7'h3F: is_minus = 1'b1;
            7'h7F: nib = 4'h0;
            default: glyph_ok = 1'b0;
        endcase
        cap_ok = glyph_ok && (!is_minus || (idx == TopIdx));
    end

    // A publish cycle clears the frame first so a coincident strobe starts the next frame
    always_comb begin
        mask_base = (state == StPublish) ? '0 : mask;
        sign_base = (state == StPublish) ? 1'b0 : psign;
        mask_new  = mask_base | sel;
    end

    // Frame FSM: collect digits, publish full frames, discard on errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            mask        <= '0;
            pending     <= '0;
            psign       <= 1'b0;
            value       <= '0;
            neg         <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
`ifdef SSEG_CAP_CONFIRM_EN
            cmp_val     <= '0;
            cmp_neg     <= 1'b0;
            cmp_loaded  <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            mask        <= mask_base;
            psign       <= sign_base;

            if (state == StPublish) begin
`ifdef SSEG_CAP_CONFIRM_EN
                if (cmp_loaded && (cmp_val == pending) && (cmp_neg == psign)) begin
                    value       <= pending;
                    neg         <= psign;
                    frame_valid <= 1'b1;
                end
                cmp_val    <= pending;
                cmp_neg    <= psign;
                cmp_loaded <= 1'b1;
`else
                value       <= pending;
                neg         <= psign;
                frame_valid <= 1'b1;
`endif
                state <= StIdle;
            end

            if (capture) begin
                if (cap_ok) begin
                    pending[{idx, 2'b00} +: 4] <= nib;
                    mask                       <= mask_new;
                    if (idx == TopIdx) psign <= is_minus;
                    state <= (&mask_new) ? StPublish : StCollect;
                end else begin
                    frame_err <= 1'b1;
                    mask      <= '0;
                    psign     <= 1'b0;
                    state     <= StIdle;
`ifdef SSEG_CAP_CONFIRM_EN
                    cmp_loaded <= 1'b0;
`endif
                end
            end

            if (multi_entry) begin
                frame_err <= 1'b1;
                mask      <= '0;
                psign     <= 1'b0;
                state     <= StIdle;
`ifdef SSEG_CAP_CONFIRM_EN
                cmp_loaded <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture (N_DIGITS=2, SETTLE=4).
module tb_sseg_scan_capture;

    localparam logic [6:0] G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19, G5 = 7'h12;
    localparam logic [6:0] G7 = 7'h78, G8 = 7'h00, G9 = 7'h10, GA = 7'h08;
    localparam logic [6:0] GMINUS = 7'h3F, GBLANK = 7'h7F, GBAD = 7'h7E;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] segs_n = 7'h7F;
    logic [1:0] dig_en = 2'b00;
    logic [7:0] value;
    logic       neg, frame_valid, frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vcount = 0;
    int ecount = 0;
    int vcyc = 0;
    int drive_cyc = 0;
    logic last_neg = 1'b0;
    logic [7:0] vals[$];

    sseg_scan_capture #(.N_DIGITS(2), .SETTLE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .segs_n      (segs_n),
        .dig_en      (dig_en),
        .value       (value),
        .neg         (neg),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) begin
                vcount++;
                vals.push_back(value);
                last_neg = neg;
                vcyc = cyc;
            end
            if (frame_err) ecount++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; holds the inputs for n cycles, returns on a falling edge
    task automatic drive(input logic [1:0] sel, input logic [6:0] s, input int n);
        dig_en = sel;
        segs_n = s;
        drive_cyc = cyc;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0, e0, lat_ref, b;
        #2;
        chk("reset_value", value, 8'h00);
        chk("reset_neg", neg, 1'b0);
        chk("reset_fv", frame_valid, 1'b0);
        chk("reset_fe", frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef SSEG_CAP_CONFIRM_EN
        // 1: '5' on digit 0, 'A' on digit 1
        v0 = vcount;
        drive(2'b01, G5, 10);
        drive(2'b10, GA, 10);
        lat_ref = drive_cyc;
        drive(2'b00, GBLANK, 4);
        chk("t1_count", vcount - v0, 1);
        chk("t1_value", vals[$], 8'hA5);
        chk("t1_neg", last_neg, 1'b0);
        chk("t1_latency", vcyc - lat_ref, 7);

        // 2: minus on digit 1, then minus on digit 0 is an error
        v0 = vcount;
        e0 = ecount;
        drive(2'b10, GMINUS, 10);
        drive(2'b01, G3, 10);
        drive(2'b00, GBLANK, 4);
        chk("t2_count", vcount - v0, 1);
        chk("t2_value", vals[$], 8'h03);
        chk("t2_neg", last_neg, 1'b1);
        drive(2'b01, GMINUS, 10);
        drive(2'b00, GBLANK, 4);
        chk("t2_err", ecount - e0, 1);
        chk("t2_novalid", vcount - v0, 1);
        chk("t2_hold", value, 8'h03);

        // 3: dwells too short to capture
        v0 = vcount;
        e0 = ecount;
        drive(2'b01, G8, 3);
        drive(2'b00, GBLANK, 3);
        drive(2'b10, G8, 3);
        drive(2'b00, GBLANK, 3);
        drive(2'b01, G8, 3);
        drive(2'b00, GBLANK, 6);
        chk("t3_novalid", vcount - v0, 0);
        chk("t3_noerr", ecount - e0, 0);
        chk("t3_hold", value, 8'h03);

        // 4: multi-hot mid-frame drops the partial frame
        v0 = vcount;
        e0 = ecount;
        drive(2'b01, G7, 10);
        drive(2'b11, G7, 6);
        drive(2'b00, GBLANK, 4);
        drive(2'b10, G2, 10);
        drive(2'b00, GBLANK, 4);
        chk("t4_err", ecount - e0, 1);
        chk("t4_cleared", vcount - v0, 0);
        drive(2'b01, G1, 10);
        drive(2'b00, GBLANK, 4);
        chk("t4_count", vcount - v0, 1);
        chk("t4_value", vals[$], 8'h21);
        chk("t4_neg", last_neg, 1'b0);

        // 5: asynchronous reset mid-frame
        v0 = vcount;
        drive(2'b01, G9, 10);
        drive(2'b00, GBLANK, 2);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_value", value, 8'h00);
        chk("t5_neg", neg, 1'b0);
        chk("t5_fv", frame_valid, 1'b0);
        chk("t5_fe", frame_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b10, G4, 10);
        drive(2'b00, GBLANK, 4);
        chk("t5_novalid", vcount - v0, 0);
        chk("t5_hold", value, 8'h00);

        // Invalid glyph flushes the pending digit 1
        e0 = ecount;
        drive(2'b01, GBAD, 10);
        drive(2'b00, GBLANK, 4);
        chk("badglyph_err", ecount - e0, 1);
`endif

        // 6: frames 12, 12, 34, 34
        b = vals.size();
        drive(2'b01, G2, 10);
        drive(2'b10, G1, 10);
        drive(2'b00, GBLANK, 4);
        drive(2'b01, G2, 10);
        drive(2'b10, G1, 10);
        drive(2'b00, GBLANK, 4);
        drive(2'b01, G4, 10);
        drive(2'b10, G3, 10);
        drive(2'b00, GBLANK, 4);
        drive(2'b01, G4, 10);
        drive(2'b10, G3, 10);
        drive(2'b00, GBLANK, 4);
`ifdef SSEG_CAP_CONFIRM_EN
        chk("t6_count", vals.size() - b, 2);
`else
        chk("t6_count", vals.size() - b, 4);
`endif
        chk("t6_first", (vals.size() > b) ? vals[b] : 8'hxx, 8'h12);
        chk("t6_last", vals[$], 8'h34);
        chk("t6_neg", last_neg, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sseg_scan_capture.md
Name: sseg_scan_capture

Overview:
Reader end of the seven-segment display interface. It samples a time-multiplexed segment bus plus its digit-select lines and decodes each digit pattern back to a hex nibble. It assembles a full N-digit frame and publishes the value, a sign flag and a one-cycle valid pulse. It lets the board loopback checks and benches read back what the display path drives, without hand-decoding the segments.

Parameters:
N_DIGITS, 2, number of multiplexed digits; the value width is 4*N_DIGITS.
SETTLE, 4, number of consecutive stable cycles of the synchronised select required before a digit is sampled; legal range 1..255.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
segs_n  input  7  segment bus, active-low; bit0=a through bit6=g
dig_en  input  N_DIGITS  digit select, active-high, expected one-hot or all-zero
value  output  4*N_DIGITS  last published frame; digit 0 in bits [3:0]
neg  output  1  last published frame carried a minus sign in the MSB digit
frame_valid  output  1  one-cycle pulse when value/neg update
frame_err  output  1  one-cycle pulse on a discarded frame

Behaviour:
- Reset: one clock, rst_n asynchronous active-low. While in reset, value=0, neg=0, frame_valid=0, frame_err=0, the synchronisers are cleared, the stability counter is 0 and the capture mask is 0.
- Synchronisation: segs_n and dig_en each pass through a 2-flop synchroniser. All logic below uses the synchronised copies (sel, seg).
- Stability counter cnt:
  - cnt resets to 0 whenever sel differs from its previous-cycle value.
  - Otherwise cnt increments and saturates at SETTLE.
  - A capture strobe fires only on the cycle cnt goes SETTLE-1 to SETTLE: exactly once per select dwell, never repeated while the select is held.
- Select validity:
  - sel all-zero: blanking interval; no capture.
  - sel multi-hot: no capture. frame_err pulses once on entry to the multi-hot condition and the mask clears.
- Decode at strobe, active-low, g..a order:
  - 0-F use the standard glyphs, lowercase b and d.
  - 0111111 (g only) = minus: legal only in digit N_DIGITS-1. It stores nibble 0 and sets the pending sign.
  - 1111111 (blank) stores nibble 0.
  - Any other pattern, or a minus in a lower digit, is invalid: frame_err pulses the next cycle, and the mask and pending sign clear.
- Frame assembly:
  - The decoded nibble writes into a pending buffer slot and sets the corresponding mask bit.
  - Re-capturing an already-set digit overwrites the slot with no error.
  - Digits may arrive in any order.
- Publish:
  - On the cycle after the mask becomes all-ones, value<=pending, neg<=pending sign and frame_valid=1 for one cycle.
  - The mask and pending sign clear in the same cycle.
  - Latency from the strobe of the completing digit to frame_valid is 1 cycle; from a segs_n/dig_en pin change it is 2 sync + SETTLE + 1 cycles.
- Simultaneous events: a strobe on the publish cycle belongs to the new frame; the clear is applied first, then the new mask bit is set.
- Between publishes, value and neg hold.
- Reset mid-frame discards the partial frame with no pulses.
- FSM: IDLE (mask=0) -> COLLECT on first valid capture -> PUBLISH when the mask is full -> IDLE. Any error returns to IDLE.

Optional Feature:
Macro SSEG_CAP_CONFIRM_EN.
- Defined: a frame publishes only if it equals the previous completed frame, comparing both value and sign. The first complete frame after reset or after an error only loads the compare register. A mismatching frame replaces the compare register silently, with no frame_err. The publish latency is unchanged relative to the confirming frame.
- Undefined: every complete frame publishes immediately, and no compare register is instantiated.

Test Plan:
1. N_DIGITS=2, SETTLE=4. Drive dig_en=01 with segs_n=0010010 ('5') for 10 cycles, then dig_en=10 with 0001000 ('A') for 10 cycles -> a single frame_valid with value=8'hA5, neg=0, occurring 2+4+1 cycles after the second select change.
2. Digit 1 = 0111111 (minus), digit 0 = 0110000 ('3') -> value=8'h03, neg=1. Then minus on digit 0 -> frame_err pulse, no frame_valid, value stays 8'h03.
3. Hold dig_en=01 for only 3 cycles per dwell (below SETTLE+1) -> no capture, no pulses, value unchanged.
4. Drive dig_en=11 for 6 cycles mid-frame -> exactly one frame_err pulse. The pending mask clears, and the next two clean digits ('1','2') publish 8'h21.
5. Assert rst_n=0 asynchronously after digit 0 is captured -> outputs are 0 immediately. After release, a single digit-1 capture does not publish.
6. With SSEG_CAP_CONFIRM_EN defined, send frames 8'h12, 8'h12, 8'h34, 8'h34 -> frame_valid is seen exactly twice, with value 8'h12 then 8'h34.
